// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
// State encodings, default timeout and reset/zero constants live here.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_REQ  = 2'd1,
    MAC_DONE = 2'd2
  } mac_state_e;

  localparam int          MAC_TIMEOUT_DEFAULT = 15;
  localparam logic        RST_ENABLE          = 1'b1;
  localparam logic [15:0] ZERO16              = 16'h0000;

endpackage

// File: rtl/mem_access_ctrl_timer.sv
// Timeout counter for the access controller: counts REQ cycles without an ack
// and flags the last permitted cycle so the FSM can abort on that edge.
module mac_timer
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMER_W = 4,
  parameter int LIMIT   = MAC_TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i == RST_ENABLE || clr_i) begin
      r_cnt <= '0;
    end else if (inc_i) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expire_o = (r_cnt == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues req/ack transactions, stalls the
// upstream pipeline while one is outstanding, captures load data, aborts on timeout.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MAC_TIMEOUT_DEFAULT,
  parameter int TIMER_W        = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_memRead_i,
  input  logic        mem_memWrite_i,
  input  logic [15:0] mem_addr_i,
  input  logic [15:0] mem_wdata_i,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [15:0] dm_addr_o,
  output logic [15:0] dm_wdata_o,
  input  logic        dm_ack_i,
  input  logic [15:0] dm_rdata_i,
  output logic        stall_o,
  output logic        wb_bubble_o,
  output logic [15:0] mem_memData_o,
  output logic        busy_o,
  output logic        timeout_err_o
);

  mac_state_e  r_state;
  mac_state_e  w_next;
  logic        w_access;
  logic        w_expire;
  logic        w_in_req;
  logic        r_we;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_data;
  logic        r_err;

  assign w_access = mem_memRead_i | mem_memWrite_i;
  assign w_in_req = (r_state == MAC_REQ);

  // Counter only advances on REQ cycles that neither complete nor abort,
  // so it can never wrap; it is held at zero outside REQ.
  mac_timer #(
    .TIMER_W (TIMER_W),
    .LIMIT   (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (!w_in_req),
    .inc_i    (w_in_req && !dm_ack_i && !w_expire),
    .expire_o (w_expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i == RST_ENABLE) begin
      r_state <= MAC_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MAC_IDLE: if (w_access) w_next = MAC_REQ;
      MAC_REQ:  if (dm_ack_i || w_expire) w_next = MAC_DONE;
      MAC_DONE: w_next = MAC_IDLE;
      default:  w_next = MAC_IDLE;
    endcase
  end

  // A write (including read+write) never touches the load-data register.
  always_ff @(posedge clk_i) begin
    if (rst_i == RST_ENABLE) begin
      r_we    <= 1'b0;
      r_addr  <= ZERO16;
      r_wdata <= ZERO16;
      r_data  <= ZERO16;
      r_err   <= 1'b0;
    end else begin
      if (r_state == MAC_IDLE && w_access) begin
        r_we    <= mem_memWrite_i;
        r_addr  <= mem_addr_i;
        r_wdata <= mem_wdata_i;
      end
      if (w_in_req) begin
        if (dm_ack_i) begin
          if (!r_we) r_data <= dm_rdata_i;
        end else if (w_expire) begin
          r_err <= 1'b1;
          if (!r_we) r_data <= ZERO16;
        end
      end
    end
  end

  assign dm_req_o      = w_in_req;
  assign dm_we_o       = r_we;
  assign dm_addr_o     = r_addr;
  assign dm_wdata_o    = r_wdata;
  assign stall_o       = ((r_state == MAC_IDLE) && w_access) || w_in_req;
  assign wb_bubble_o   = stall_o;
  assign busy_o        = (r_state != MAC_IDLE);
  assign mem_memData_o = r_data;
  assign timeout_err_o = r_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a behavioural slave answers requests
// after a chosen number of REQ cycles and a queue holds the expected load data.
module tb_mem_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_memRead_i = 1'b0;
  logic        mem_memWrite_i = 1'b0;
  logic [15:0] mem_addr_i = 16'h0000;
  logic [15:0] mem_wdata_i = 16'h0000;
  logic        dm_req_o;
  logic        dm_we_o;
  logic [15:0] dm_addr_o;
  logic [15:0] dm_wdata_o;
  logic        dm_ack_i = 1'b0;
  logic [15:0] dm_rdata_i = 16'h0000;
  logic        stall_o;
  logic        wb_bubble_o;
  logic [15:0] mem_memData_o;
  logic        busy_o;
  logic        timeout_err_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_data = 16'h0000;

  mem_access_ctrl #(.TIMEOUT_CYCLES(15), .TIMER_W(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .mem_memRead_i  (mem_memRead_i),
    .mem_memWrite_i (mem_memWrite_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .dm_req_o       (dm_req_o),
    .dm_we_o        (dm_we_o),
    .dm_addr_o      (dm_addr_o),
    .dm_wdata_o     (dm_wdata_o),
    .dm_ack_i       (dm_ack_i),
    .dm_rdata_i     (dm_rdata_i),
    .stall_o        (stall_o),
    .wb_bubble_o    (wb_bubble_o),
    .mem_memData_o  (mem_memData_o),
    .busy_o         (busy_o),
    .timeout_err_o  (timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Entered at a negedge with the FSM in IDLE; returns at the negedge of DONE.
  // ack_at = k acks in the k-th REQ cycle; 0 never acks.
  task automatic run_access(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [15:0] wdata, input int ack_at, input logic [15:0] rdata,
                            output int stalls, output int reqs, output bit stable,
                            output bit bubble_ok, output bit done_seen,
                            output logic [15:0] data_done, output logic [15:0] addr_seen,
                            output logic [15:0] wdata_seen, output logic we_seen);
    int cyc;
    stalls = 0; reqs = 0; stable = 1'b1; bubble_ok = 1'b1; done_seen = 1'b0;
    data_done = '0; addr_seen = '0; wdata_seen = '0; we_seen = 1'b0;
    mem_memRead_i = rd; mem_memWrite_i = wr; mem_addr_i = addr; mem_wdata_i = wdata;
    dm_rdata_i = rdata; dm_ack_i = 1'b0;
    #1;
    cyc = 0;
    while (!done_seen && cyc < 40) begin
      if (wb_bubble_o !== stall_o) bubble_ok = 1'b0;
      if (stall_o) stalls++;
      if (dm_req_o) begin
        reqs++;
        if (reqs == 1) begin
          addr_seen = dm_addr_o; wdata_seen = dm_wdata_o; we_seen = dm_we_o;
        end else if (dm_addr_o !== addr_seen || dm_wdata_o !== wdata_seen || dm_we_o !== we_seen) begin
          stable = 1'b0;
        end
        dm_ack_i = (reqs == ack_at);
      end else begin
        dm_ack_i = 1'b0;
        if (busy_o && !stall_o) begin
          done_seen = 1'b1;
          data_done = mem_memData_o;
          mem_memRead_i = 1'b0;
          mem_memWrite_i = 1'b0;
        end
      end
      if (!done_seen) begin
        @(negedge clk_i);
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
    n_checks++; if (dm_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", dm_req_o); end
    n_checks++; if ({dm_we_o, dm_addr_o, dm_wdata_o} !== 33'd0) begin n_fail++; $display("FAIL rst_dm_regs: got we=%b addr=%h wdata=%h expected all 0", dm_we_o, dm_addr_o, dm_wdata_o); end
    n_checks++; if (mem_memData_o !== 16'h0000) begin n_fail++; $display("FAIL rst_data: got %h expected 0000", mem_memData_o); end
    n_checks++; if (timeout_err_o !== 1'b0 || stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_err_stall: got err=%b stall=%b expected 0 0", timeout_err_o, stall_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_release_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_load();
    int st, rq; bit stb, bub, dn; logic [15:0] d, a, w; logic we;
    exp_data = 16'hBEEF; exp_q.push_back(exp_data);
    run_access(1'b1, 1'b0, 16'h0040, 16'h0000, 1, 16'hBEEF, st, rq, stb, bub, dn, d, a, w, we);
    n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL load_done: got %b expected 1", dn); end
    n_checks++; if (st !== 2) begin n_fail++; $display("FAIL load_stalls: got %0d expected 2", st); end
    n_checks++; if (bub !== 1'b1) begin n_fail++; $display("FAIL load_bubble: wb_bubble_o differed from stall_o"); end
    n_checks++; if (a !== 16'h0040 || we !== 1'b0) begin n_fail++; $display("FAIL load_addr_we: got addr=%h we=%b expected 0040 0", a, we); end
    n_checks++; if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL load_data: got %h expected %h", d, exp_data); end
    @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL load_idle_after: busy got %b expected 0", busy_o); end
  endtask

  task automatic test_store();
    int st, rq; bit stb, bub, dn; logic [15:0] d, a, w; logic we;
    exp_q.push_back(exp_data);
    run_access(1'b0, 1'b1, 16'h0010, 16'h1234, 3, 16'hCAFE, st, rq, stb, bub, dn, d, a, w, we);
    n_checks++; if (st !== 4 || rq !== 3) begin n_fail++; $display("FAIL store_cycles: got stalls=%0d reqs=%0d expected 4 3", st, rq); end
    n_checks++; if (stb !== 1'b1 || we !== 1'b1) begin n_fail++; $display("FAIL store_stable_we: got stable=%b we=%b expected 1 1", stb, we); end
    n_checks++; if (a !== 16'h0010 || w !== 16'h1234) begin n_fail++; $display("FAIL store_addr_wdata: got %h %h expected 0010 1234", a, w); end
    n_checks++; if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL store_data_kept: got %h expected %h", d, exp_data); end
    @(negedge clk_i);
    // Read and write together behave as a write.
    exp_q.push_back(exp_data);
    run_access(1'b1, 1'b1, 16'h0020, 16'h5555, 1, 16'hAAAA, st, rq, stb, bub, dn, d, a, w, we);
    n_checks++; if (we !== 1'b1 || w !== 16'h5555) begin n_fail++; $display("FAIL rdwr_as_write: got we=%b wdata=%h expected 1 5555", we, w); end
    n_checks++; if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL rdwr_data_kept: got %h expected %h", d, exp_data); end
    @(negedge clk_i);
  endtask

  task automatic test_timeout();
    int st, rq; bit stb, bub, dn; logic [15:0] d, a, w; logic we;
    n_checks++; if (timeout_err_o !== 1'b0) begin n_fail++; $display("FAIL to_err_before: got %b expected 0", timeout_err_o); end
    exp_data = 16'h0000; exp_q.push_back(exp_data);
    run_access(1'b1, 1'b0, 16'h0080, 16'h0000, 0, 16'h7777, st, rq, stb, bub, dn, d, a, w, we);
    n_checks++; if (dn !== 1'b1 || rq !== 15) begin n_fail++; $display("FAIL to_req_cycles: got done=%b reqs=%0d expected 1 15", dn, rq); end
    n_checks++; if (st !== 16) begin n_fail++; $display("FAIL to_stalls: got %0d expected 16", st); end
    n_checks++; if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL to_data: got %h expected %h", d, exp_data); end
    n_checks++; if (timeout_err_o !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b expected 1", timeout_err_o); end
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    int st, rq; bit stb, bub, dn; logic [15:0] d, a, w; logic we;
    exp_data = 16'h1111; exp_q.push_back(exp_data);
    run_access(1'b1, 1'b0, 16'h0100, 16'h0000, 1, 16'h1111, st, rq, stb, bub, dn, d, a, w, we);
    n_checks++; if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL b2b_data1: got %h expected %h", d, exp_data); end
    @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b0 || dm_req_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got busy=%b req=%b expected 0 0", busy_o, dm_req_o); end
    exp_data = 16'h2222; exp_q.push_back(exp_data);
    run_access(1'b1, 1'b0, 16'h0102, 16'h0000, 1, 16'h2222, st, rq, stb, bub, dn, d, a, w, we);
    n_checks++; if (st !== 2 || rq !== 1 || a !== 16'h0102) begin n_fail++; $display("FAIL b2b_second: got stalls=%0d reqs=%0d addr=%h expected 2 1 0102", st, rq, a); end
    n_checks++; if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL b2b_data2: got %h expected %h", d, exp_data); end
    n_checks++; if (timeout_err_o !== 1'b1) begin n_fail++; $display("FAIL b2b_err_sticky: got %b expected 1", timeout_err_o); end
    @(negedge clk_i);
  endtask

  task automatic test_spurious_ack();
    mem_memRead_i = 1'b0; mem_memWrite_i = 1'b0;
    dm_ack_i = 1'b1; dm_rdata_i = 16'hDEAD;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL spur_stall: got %b expected 0", stall_o); end
    repeat (2) @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b0 || dm_req_o !== 1'b0) begin n_fail++; $display("FAIL spur_state: got busy=%b req=%b expected 0 0", busy_o, dm_req_o); end
    n_checks++; if (mem_memData_o !== exp_data) begin n_fail++; $display("FAIL spur_data: got %h expected %h", mem_memData_o, exp_data); end
    dm_ack_i = 1'b0;
  endtask

  task automatic test_reset_in_req();
    mem_memRead_i = 1'b1; mem_memWrite_i = 1'b0; mem_addr_i = 16'h0200; dm_ack_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (dm_req_o !== 1'b1) begin n_fail++; $display("FAIL rreq_first: got req=%b expected 1", dm_req_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    exp_data = 16'h0000; exp_q.push_back(exp_data);
    n_checks++; if (busy_o !== 1'b0 || dm_req_o !== 1'b0) begin n_fail++; $display("FAIL rreq_idle: got busy=%b req=%b expected 0 0", busy_o, dm_req_o); end
    n_checks++; if ({dm_we_o, dm_addr_o, dm_wdata_o, timeout_err_o} !== 34'd0) begin n_fail++; $display("FAIL rreq_regs: got we=%b addr=%h wdata=%h err=%b expected all 0", dm_we_o, dm_addr_o, dm_wdata_o, timeout_err_o); end
    n_checks++; if (mem_memData_o !== exp_q.pop_front()) begin n_fail++; $display("FAIL rreq_data: got %h expected %h", mem_memData_o, exp_data); end
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rreq_stall_access: got %b expected 1", stall_o); end
    rst_i = 1'b0; mem_memRead_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b0 || stall_o !== 1'b0) begin n_fail++; $display("FAIL rreq_no_retry: got busy=%b stall=%b expected 0 0", busy_o, stall_o); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_back_to_back();
    test_spurious_ack();
    test_reset_in_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
